// File: rtl/avalon_arbiter_2h.sv
// rtl/avalon_arbiter_2h.sv - burst-aware two-host Avalon-MM arbiter; AVALON_ARB_FIXED_PRIO_EN selects fixed host-0 priority
module avalon_arbiter_2h #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BURSTCOUNT_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [ADDR_W-1:0]       h0_address,
    input  logic                    h0_read,
    input  logic                    h0_write,
    input  logic [DATA_W-1:0]       h0_writedata,
    input  logic [DATA_W/8-1:0]     h0_byteenable,
    input  logic [BURSTCOUNT_W-1:0] h0_burstcount,
    output logic                    h0_waitrequest,
    output logic [DATA_W-1:0]       h0_readdata,
    output logic                    h0_readdatavalid,

    input  logic [ADDR_W-1:0]       h1_address,
    input  logic                    h1_read,
    input  logic                    h1_write,
    input  logic [DATA_W-1:0]       h1_writedata,
    input  logic [DATA_W/8-1:0]     h1_byteenable,
    input  logic [BURSTCOUNT_W-1:0] h1_burstcount,
    output logic                    h1_waitrequest,
    output logic [DATA_W-1:0]       h1_readdata,
    output logic                    h1_readdatavalid,

    output logic [ADDR_W-1:0]       a_address,
    output logic                    a_read,
    output logic                    a_write,
    output logic [DATA_W-1:0]       a_writedata,
    output logic [DATA_W/8-1:0]     a_byteenable,
    output logic [BURSTCOUNT_W-1:0] a_burstcount,
    input  logic                    a_waitrequest,
    input  logic [DATA_W-1:0]       a_readdata,
    input  logic                    a_readdatavalid
);

    localparam logic [BURSTCOUNT_W-1:0] ONE = BURSTCOUNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_CMD   = 2'd2,
        RD_DATA  = 2'd3
    } state_t;

    state_t                  state;
    logic                    grant;
    logic [BURSTCOUNT_W-1:0] len;
    logic [BURSTCOUNT_W-1:0] count;
`ifndef AVALON_ARB_FIXED_PRIO_EN
    logic                    last_grant;
`endif

    logic                    req0;
    logic                    req1;
    logic                    tie_winner;
    logic                    pick;
    logic                    pick_read;
    logic [BURSTCOUNT_W-1:0] pick_bc;
    logic [BURSTCOUNT_W-1:0] pick_len;
    logic                    burst_last;
    logic                    g_write;

    assign req0 = h0_read | h0_write;
    assign req1 = h1_read | h1_write;

`ifdef AVALON_ARB_FIXED_PRIO_EN
    assign tie_winner = 1'b0;
`else
    assign tie_winner = ~last_grant;
`endif

    // A lone requester wins outright; only a tie consults the tie-break.
    assign pick      = (req0 & req1) ? tie_winner : req1;
    assign pick_read = pick ? h1_read : h0_read;
    assign pick_bc   = pick ? h1_burstcount : h0_burstcount;
    assign pick_len  = (pick_bc == '0) ? ONE : pick_bc;

    assign burst_last = (count == (len - ONE));
    assign g_write    = grant ? h1_write : h0_write;

    // Both hosts see the agent's read data; only the valid strobe is steered.
    assign h0_readdata = a_readdata;
    assign h1_readdata = a_readdata;

    // Route the granted host onto the agent and steer handshakes back to it.
    always_comb begin
        a_address        = grant ? h1_address    : h0_address;
        a_writedata      = grant ? h1_writedata  : h0_writedata;
        a_byteenable     = grant ? h1_byteenable : h0_byteenable;
        a_burstcount     = grant ? h1_burstcount : h0_burstcount;
        a_read           = (state == RD_CMD);
        a_write          = (state == WR_BURST) & g_write;
        h0_waitrequest   = 1'b1;
        h1_waitrequest   = 1'b1;
        h0_readdatavalid = (state == RD_DATA) & ~grant & a_readdatavalid;
        h1_readdatavalid = (state == RD_DATA) &  grant & a_readdatavalid;
        if (state == WR_BURST || state == RD_CMD) begin
            if (grant) begin
                h1_waitrequest = a_waitrequest;
            end else begin
                h0_waitrequest = a_waitrequest;
            end
        end
    end

    // Burst FSM: latch grant and length in IDLE, count beats until the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            len        <= '0;
            count      <= '0;
`ifndef AVALON_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        grant <= pick;
                        len   <= pick_len;
                        count <= '0;
                        state <= pick_read ? RD_CMD : WR_BURST;
                    end
                end
                WR_BURST: begin
                    if (a_write & ~a_waitrequest) begin
                        if (burst_last) begin
                            state      <= IDLE;
                            count      <= '0;
`ifndef AVALON_ARB_FIXED_PRIO_EN
                            last_grant <= grant;
`endif
                        end else begin
                            count <= count + ONE;
                        end
                    end
                end
                RD_CMD: begin
                    if (~a_waitrequest) begin
                        state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (a_readdatavalid) begin
                        if (burst_last) begin
                            state      <= IDLE;
                            count      <= '0;
`ifndef AVALON_ARB_FIXED_PRIO_EN
                            last_grant <= grant;
`endif
                        end else begin
                            count <= count + ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_arbiter_2h.sv
// tb/tb_avalon_arbiter_2h.sv - self-checking bench for avalon_arbiter_2h
module tb_avalon_arbiter_2h;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] h_addr [2];
    logic          h_rd   [2];
    logic          h_wr   [2];
    logic [DW-1:0] h_wd   [2];
    logic [3:0]    h_be   [2];
    logic [BW-1:0] h_bc   [2];
    logic          h_wait [2];
    logic [DW-1:0] h_rdata[2];
    logic          h_rdv  [2];

    logic [AW-1:0] a_address;
    logic          a_read;
    logic          a_write;
    logic [DW-1:0] a_writedata;
    logic [3:0]    a_byteenable;
    logic [BW-1:0] a_burstcount;
    logic          a_waitrequest;
    logic [DW-1:0] a_readdata;
    logic          a_readdatavalid;

    avalon_arbiter_2h #(.ADDR_W(AW), .DATA_W(DW), .BURSTCOUNT_W(BW)) dut (
        .clk(clk), .reset(reset),
        .h0_address(h_addr[0]), .h0_read(h_rd[0]), .h0_write(h_wr[0]),
        .h0_writedata(h_wd[0]), .h0_byteenable(h_be[0]), .h0_burstcount(h_bc[0]),
        .h0_waitrequest(h_wait[0]), .h0_readdata(h_rdata[0]), .h0_readdatavalid(h_rdv[0]),
        .h1_address(h_addr[1]), .h1_read(h_rd[1]), .h1_write(h_wr[1]),
        .h1_writedata(h_wd[1]), .h1_byteenable(h_be[1]), .h1_burstcount(h_bc[1]),
        .h1_waitrequest(h_wait[1]), .h1_readdata(h_rdata[1]), .h1_readdatavalid(h_rdv[1]),
        .a_address(a_address), .a_read(a_read), .a_write(a_write),
        .a_writedata(a_writedata), .a_byteenable(a_byteenable), .a_burstcount(a_burstcount),
        .a_waitrequest(a_waitrequest), .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit stall_mode = 0;
    int agent_wr_beats = 0;
    int rdv_cnt[2];
    int rd_cnt[2];
    logic [DW-1:0] rd_got[2][8];
    int order_q[$];
    int last_acc[2];
    int h1_first = -1;
    logic [DW-1:0] mem [0:255];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bench agent: BRAM with optional stall pattern, read beats returned in order.
    initial begin
        logic [DW-1:0] rq[$];
        int wr_idx;
        int wr_n;
        logic [7:0] wr_base;
        int n;
        wr_idx = 0; wr_n = 1; wr_base = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        a_waitrequest = 1'b0; a_readdata = '0; a_readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            if (a_write && !a_waitrequest) begin
                if (wr_idx == 0) begin
                    wr_base = a_address[7:0];
                    wr_n = (a_burstcount == 0) ? 1 : int'(a_burstcount);
                end
                mem[wr_base + 8'(wr_idx)] = a_writedata;
                agent_wr_beats++;
                wr_idx++;
                if (wr_idx == wr_n) wr_idx = 0;
            end
            if (a_read && !a_waitrequest) begin
                n = (a_burstcount == 0) ? 1 : int'(a_burstcount);
                for (int i = 0; i < n; i++) rq.push_back(mem[a_address[7:0] + 8'(i)]);
            end
            @(posedge clk);
            #1;
            a_waitrequest = stall_mode && (cyc % 3 == 1);
            if (rq.size() > 0) begin
                a_readdatavalid = 1'b1;
                a_readdata = rq.pop_front();
            end else begin
                a_readdatavalid = 1'b0;
                a_readdata = '0;
            end
        end
    end

    // Observers for read-beat counts and the first h1 write seen at the agent.
    initial begin
        rdv_cnt[0] = 0; rdv_cnt[1] = 0;
        forever begin
            @(negedge clk);
            if (h_rdv[0] === 1'b1) rdv_cnt[0]++;
            if (h_rdv[1] === 1'b1) rdv_cnt[1]++;
            if (a_write === 1'b1 && a_address == 32'h30 && h1_first < 0) h1_first = cyc;
        end
    end

    // Transaction-level model: owner of the agent, remaining beats, tie-break history.
    initial begin
        int own; int prev; int left; int win; int oth;
        bit is_rd; bit cmd_pending; bit r0; bit r1;
        own = -1; prev = 1; left = 0; is_rd = 0; cmd_pending = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("m_rst_h0_wait", h_wait[0], 1); chk("m_rst_h1_wait", h_wait[1], 1);
                chk("m_rst_h0_rdv", h_rdv[0], 0);   chk("m_rst_h1_rdv", h_rdv[1], 0);
                chk("m_rst_a_read", a_read, 0);     chk("m_rst_a_write", a_write, 0);
                own = -1; prev = 1;
            end else if (own < 0) begin
                chk("m_idle_h0_wait", h_wait[0], 1); chk("m_idle_h1_wait", h_wait[1], 1);
                chk("m_idle_h0_rdv", h_rdv[0], 0);   chk("m_idle_h1_rdv", h_rdv[1], 0);
                chk("m_idle_a_read", a_read, 0);     chk("m_idle_a_write", a_write, 0);
                r0 = h_rd[0] | h_wr[0];
                r1 = h_rd[1] | h_wr[1];
                if (r0 || r1) begin
`ifdef AVALON_ARB_FIXED_PRIO_EN
                    win = (r0 && r1) ? 0 : (r1 ? 1 : 0);
`else
                    win = (r0 && r1) ? 1 - prev : (r1 ? 1 : 0);
`endif
                    own = win;
                    is_rd = h_rd[win];
                    cmd_pending = is_rd;
                    left = (h_bc[win] == 0) ? 1 : int'(h_bc[win]);
                end
            end else begin
                oth = 1 - own;
                chk("m_other_wait", h_wait[oth], 1);
                chk("m_other_rdv", h_rdv[oth], 0);
                if (!is_rd) begin
                    chk("m_wr_a_write", a_write, h_wr[own]);
                    chk("m_wr_a_read", a_read, 0);
                    chk("m_wr_own_wait", h_wait[own], a_waitrequest);
                    chk("m_wr_own_rdv", h_rdv[own], 0);
                    if (h_wr[own]) begin
                        chk("m_wr_addr", a_address, h_addr[own]);
                        chk("m_wr_data", a_writedata, h_wd[own]);
                        chk("m_wr_be", a_byteenable, h_be[own]);
                        chk("m_wr_bc", a_burstcount, h_bc[own]);
                        if (!a_waitrequest) begin
                            left--;
                            if (left == 0) begin prev = own; own = -1; end
                        end
                    end
                end else if (cmd_pending) begin
                    chk("m_rc_a_read", a_read, 1);
                    chk("m_rc_a_write", a_write, 0);
                    chk("m_rc_own_wait", h_wait[own], a_waitrequest);
                    chk("m_rc_addr", a_address, h_addr[own]);
                    chk("m_rc_bc", a_burstcount, h_bc[own]);
                    chk("m_rc_own_rdv", h_rdv[own], 0);
                    if (!a_waitrequest) cmd_pending = 0;
                end else begin
                    chk("m_rd_a_read", a_read, 0);
                    chk("m_rd_a_write", a_write, 0);
                    chk("m_rd_own_wait", h_wait[own], 1);
                    chk("m_rd_own_rdv", h_rdv[own], a_readdatavalid);
                    if (a_readdatavalid) begin
                        chk("m_rd_data", h_rdata[own], a_readdata);
                        left--;
                        if (left == 0) begin prev = own; own = -1; end
                    end
                end
            end
        end
    end

    task automatic do_write(input int h, input logic [31:0] addr, input logic [3:0] bc,
                            input logic [31:0] d0, input int bubble_after);
        int n;
        int t;
        n = (bc == 0) ? 1 : int'(bc);
        h_addr[h] = addr; h_bc[h] = bc; h_be[h] = 4'hF;
        for (int i = 0; i < n; i++) begin
            h_wr[h] = 1'b1;
            h_wd[h] = d0 + 32'(i);
            t = 0;
            forever begin
                @(negedge clk);
                if (!h_wait[h]) break;
                t++;
                if (t > 300) begin
                    errors++;
                    $display("FAIL write_timeout host=%0d beat=%0d actual=stalled expected=accepted", h, i);
                    break;
                end
            end
            if (i == 0) order_q.push_back(h);
            last_acc[h] = cyc;
            @(posedge clk);
            #1;
            if (bubble_after == i + 1) begin
                h_wr[h] = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
        end
        h_wr[h] = 1'b0;
    endtask

    task automatic do_read(input int h, input logic [31:0] addr, input logic [3:0] bc,
                           input int stop_after);
        int n;
        int t;
        int k;
        n = (bc == 0) ? 1 : int'(bc);
        h_addr[h] = addr; h_bc[h] = bc; h_rd[h] = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (!h_wait[h]) break;
            t++;
            if (t > 300) begin
                errors++;
                $display("FAIL read_cmd_timeout host=%0d actual=stalled expected=accepted", h);
                break;
            end
        end
        order_q.push_back(h);
        @(posedge clk);
        #1;
        h_rd[h] = 1'b0;
        k = 0; t = 0;
        while (k < n && k < stop_after) begin
            @(negedge clk);
            if (h_rdv[h]) begin
                rd_got[h][k] = h_rdata[h];
                k++;
            end else begin
                t++;
                if (t > 300) begin
                    errors++;
                    $display("FAIL read_data_timeout host=%0d actual=%0d expected=%0d", h, k, n);
                    break;
                end
            end
        end
        rd_cnt[h] = k;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int r0;
        int r1;
        int wb0;
        int exp_ord[4];
        for (int h = 0; h < 2; h++) begin
            h_addr[h] = '0; h_rd[h] = 0; h_wr[h] = 0; h_wd[h] = '0; h_be[h] = 4'hF; h_bc[h] = 4'd1;
            last_acc[h] = 0; rd_cnt[h] = 0;
        end

        @(negedge clk);
        chk("reset_h0_wait", h_wait[0], 1);
        chk("reset_h1_wait", h_wait[1], 1);
        chk("reset_a_write", a_write, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // single write, one-cycle arbitration latency
        h_addr[0] = 32'h10; h_wd[0] = 32'hCAFEBABE; h_bc[0] = 4'd1; h_wr[0] = 1'b1;
        @(negedge clk);
        chk("t1_idle_a_write", a_write, 0);
        chk("t1_idle_h0_wait", h_wait[0], 1);
        @(negedge clk);
        chk("t1_a_write", a_write, 1);
        chk("t1_a_address", a_address, 32'h10);
        chk("t1_a_writedata", a_writedata, 32'hCAFEBABE);
        chk("t1_h0_wait", h_wait[0], 0);
        @(posedge clk); #1;
        h_wr[0] = 1'b0;
        @(negedge clk);
        chk("t1_back_idle_h0_wait", h_wait[0], 1);
        chk("t1_mem", mem[8'h10], 32'hCAFEBABE);
        @(posedge clk); #1;

        // h0 write burst, h1 reads it back under agent stalls
        stall_mode = 1;
        r0 = rdv_cnt[0];
        do_write(0, 32'h0, 4'd4, 32'hA0000000, 0);
        do_read(1, 32'h0, 4'd4, 99);
        chk("t2_h1_beats", rd_cnt[1], 4);
        for (int i = 0; i < 4; i++) chk("t2_h1_data", rd_got[1][i], 32'hA0000000 + 32'(i));
        chk("t2_h0_no_rdv", rdv_cnt[0] - r0, 0);
        stall_mode = 0;

        // continuous contention: grant sequence
        order_q.delete();
        fork
            begin for (int j = 0; j < 4; j++) do_read(0, 32'h0, 4'd2, 99); end
            begin for (int j = 0; j < 4; j++) do_read(1, 32'h2, 4'd2, 99); end
        join
`ifdef AVALON_ARB_FIXED_PRIO_EN
        exp_ord = '{0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 0, 1};
`endif
        chk("t3_order_len", order_q.size(), 8);
        for (int i = 0; i < 4; i++) chk("t3_grant_order", order_q[i], exp_ord[i]);

        // h1 waits out an h0 burst of 4, granted after one idle cycle
        stall_mode = 1;
        h1_first = -1;
        fork
            do_write(0, 32'h20, 4'd4, 32'hB0000000, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                do_write(1, 32'h30, 4'd2, 32'hC0000000, 0);
            end
        join
        chk("t4_h1_after_h0", h1_first, last_acc[0] + 2);
        chk("t4_mem_h0", mem[8'h23], 32'hB0000003);
        chk("t4_mem_h1", mem[8'h31], 32'hC0000001);
        stall_mode = 0;

        // write burst 3 with a 2-cycle bubble after beat 1
        wb0 = agent_wr_beats;
        do_write(0, 32'h40, 4'd3, 32'h50000000, 1);
        chk("t5_agent_beats", agent_wr_beats - wb0, 3);
        chk("t5_mem_last", mem[8'h42], 32'h50000002);

        // burstcount 0 behaves as a single beat
        wb0 = agent_wr_beats;
        do_write(1, 32'h50, 4'd0, 32'h00000077, 0);
        chk("t5b_bc0_beats", agent_wr_beats - wb0, 1);
        chk("t5b_bc0_mem", mem[8'h50], 32'h00000077);

        // reset after 2 of 4 read beats
        do_read(0, 32'h0, 4'd4, 2);
        chk("t6_beats_before_reset", rd_cnt[0], 2);
        chk("t6_beat1", rd_got[0][1], 32'hA0000001);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_h0_wait", h_wait[0], 1);
        chk("t6_rst_h0_rdv", h_rdv[0], 0);
        chk("t6_rst_a_read", a_read, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        r0 = rdv_cnt[0]; r1 = rdv_cnt[1];
        repeat (5) @(posedge clk);
        #1;
        chk("t6_late_h0_dropped", rdv_cnt[0] - r0, 0);
        chk("t6_late_h1_dropped", rdv_cnt[1] - r1, 0);
        do_read(1, 32'h40, 4'd3, 99);
        chk("t6_after_beats", rd_cnt[1], 3);
        for (int i = 0; i < 3; i++) chk("t6_after_data", rd_got[1][i], 32'h50000000 + 32'(i));

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
